// File: rtl/sr_drive_seq.sv
// sr_drive_seq: fixed-width, mutually exclusive s/r pulse sequencer with dead time.
// Define SR_SEQ_CHECK_EN to add the q feedback CHECK state and the sticky err flag.
module sr_drive_seq #(
  parameter int PULSE_W = 2,
  parameter int DEAD_T  = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic set_req,
  input  logic clr_req,
  input  logic q_fb,
  output logic s,
  output logic r,
  output logic busy,
  output logic done,
  output logic err,
  output logic ovf
);

  localparam int MX = (PULSE_W > DEAD_T) ? PULSE_W : DEAD_T;
  localparam int CW = $clog2(MX + 1);
  localparam logic [CW-1:0] P_LD = CW'(PULSE_W - 1);
  localparam logic [CW-1:0] D_LD = CW'(DEAD_T - 1);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
`ifdef SR_SEQ_CHECK_EN
    DEAD,
    CHECK
`else
    DEAD
`endif
  } state_t;

  state_t state, nxt;
  logic [CW-1:0] cnt, cnt_n;
  logic cmd, cmd_n;
  logic pv, pv_n;
  logic pc, pc_n;
  logic fin;
  logic ovf_n;
  logic done_n;
  logic req_v, req_c;

  // clear wins; cmd/pc hold the expected q (1 = set)
  assign req_v = set_req | clr_req;
  assign req_c = ~clr_req;

`ifdef SR_SEQ_CHECK_EN
  logic err_q, err_n;
  assign err = err_q;
`else
  logic unused_q_fb;
  assign unused_q_fb = q_fb;
  assign err = 1'b0;
`endif

  always_comb begin
    nxt   = state;
    cnt_n = cnt;
    cmd_n = cmd;
    pv_n  = pv;
    pc_n  = pc;
    ovf_n = 1'b0;
    fin   = 1'b0;
`ifdef SR_SEQ_CHECK_EN
    err_n = err_q;
`endif
    if (state != IDLE && req_v) begin
      ovf_n = pv;
      pv_n  = 1'b1;
      pc_n  = req_c;
    end
    unique case (state)
      IDLE: begin
        if (req_v) begin
          nxt   = DRIVE;
          cnt_n = P_LD;
          cmd_n = req_c;
        end
      end
      DRIVE: begin
        if (cnt == '0) begin
          nxt   = DEAD;
          cnt_n = D_LD;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      DEAD: begin
        if (cnt != '0) begin
          cnt_n = cnt - CW'(1);
        end else begin
`ifdef SR_SEQ_CHECK_EN
          nxt   = CHECK;
          cnt_n = '0;
`else
          fin = 1'b1;
`endif
        end
      end
`ifdef SR_SEQ_CHECK_EN
      CHECK: begin
        fin   = 1'b1;
        err_n = err_q | (q_fb != cmd);
      end
`endif
      default: nxt = IDLE;
    endcase
    // a request sampled on the deciding edge beats the older pending one
    if (fin) begin
      pv_n = 1'b0;
      if (req_v || pv) begin
        nxt   = DRIVE;
        cnt_n = P_LD;
        cmd_n = req_v ? req_c : pc;
      end else begin
        nxt   = IDLE;
        cnt_n = '0;
      end
    end
  end

`ifdef SR_SEQ_CHECK_EN
  assign done_n = (nxt == CHECK);
`else
  assign done_n = (nxt == DEAD) && (cnt_n == '0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      cmd   <= 1'b0;
      pv    <= 1'b0;
      pc    <= 1'b0;
      s     <= 1'b0;
      r     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= cnt_n;
      cmd   <= cmd_n;
      pv    <= pv_n;
      pc    <= pc_n;
      s     <= (nxt == DRIVE) & cmd_n;
      r     <= (nxt == DRIVE) & ~cmd_n;
      busy  <= (nxt != IDLE);
      done  <= done_n;
      ovf   <= ovf_n;
    end
  end

`ifdef SR_SEQ_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_n;
  end
`endif

endmodule

// File: tb/tb_sr_drive_seq.sv
// tb_sr_drive_seq: directed checks of sr_drive_seq (PULSE_W=2, DEAD_T=1).
// Expectations follow the SR_SEQ_CHECK_EN setting of the build.
module tb_sr_drive_seq;

`ifdef SR_SEQ_CHECK_EN
  localparam int LAT = 4;
  localparam logic ERR1 = 1'b1;
`else
  localparam int LAT = 3;
  localparam logic ERR1 = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic set_req = 1'b0;
  logic clr_req = 1'b0;
  logic q_fb;
  logic s, r, busy, done, err, ovf;
  logic q_ff;
  logic hold = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sr_drive_seq #(.PULSE_W(2), .DEAD_T(1)) dut (
    .clk(clk), .rst(rst),
    .set_req(set_req), .clr_req(clr_req),
    .q_fb(q_fb),
    .s(s), .r(r), .busy(busy),
    .done(done), .err(err), .ovf(ovf)
  );

  // downstream flip-flop; hold forces q high to fake a stuck output
  always @(posedge clk or posedge rst) begin
    if (rst) q_fb_reset();
    else if (r) q_ff <= 1'b0;
    else if (s) q_ff <= 1'b1;
  end
  task automatic q_fb_reset();
    q_ff <= 1'b0;
  endtask
  assign q_fb = hold ? 1'b1 : q_ff;

  task automatic chk(input string tag, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%b want=%b t=%0t", tag, got, want, $time);
    end
  endtask

  // present inputs for the next edge, then observe the following cycle
  task automatic step(input logic sr, input logic cr);
    set_req = sr;
    clr_req = cr;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_s", s, 1'b0);
    chk("rst_r", r, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // single set
    for (int k = 1; k <= 6; k++) begin
      step(k == 1, 1'b0);
      chk("set_s", s, k <= 2);
      chk("set_r", r, 1'b0);
      chk("set_busy", busy, k <= LAT);
      chk("set_done", done, k == LAT);
      chk("set_err", err, 1'b0);
    end

    // simultaneous set+clear: clear wins
    for (int k = 1; k <= 6; k++) begin
      step(k == 1, k == 1);
      chk("both_s", s, 1'b0);
      chk("both_r", r, k <= 2);
      chk("both_done", done, k == LAT);
    end

    // set@0, clr@2 pending, set@3 overwrites it
    for (int k = 1; k <= 2 * LAT + 2; k++) begin
      step(k == 1 || k == 4, k == 3);
      chk("ovf_ovf", ovf, k == 4);
      chk("ovf_s", s, k <= 2 || k == LAT + 1 || k == LAT + 2);
      chk("ovf_r", r, 1'b0);
      chk("ovf_done", done, k == LAT || k == 2 * LAT);
      chk("ovf_busy", busy, k <= 2 * LAT);
    end

    // clear while q stuck high
    hold = 1'b1;
    for (int k = 1; k <= LAT + 2; k++) begin
      step(1'b0, k == 1);
      chk("bad_r", r, k <= 2);
      chk("bad_err", err, (k > LAT) ? ERR1 : 1'b0);
    end
    hold = 1'b0;
    for (int k = 1; k <= LAT + 2; k++) begin
      step(k == 1, 1'b0);
      chk("sticky_s", s, k <= 2);
      chk("sticky_err", err, ERR1);
    end
    rst = 1'b1;
    #1;
    chk("errclr", err, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // reset mid-drive with a pending clear
    step(1'b1, 1'b0);
    chk("mid_s1", s, 1'b1);
    step(1'b0, 1'b1);
    chk("mid_s2", s, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_s_async", s, 1'b0);
    chk("mid_busy_async", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step(1'b0, 1'b0);
      chk("post_s", s, 1'b0);
      chk("post_r", r, 1'b0);
      chk("post_busy", busy, 1'b0);
      chk("post_done", done, 1'b0);
    end
    for (int k = 1; k <= 6; k++) begin
      step(k == 1, 1'b0);
      chk("resume_s", s, k <= 2);
      chk("resume_done", done, k == LAT);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
